// File: rtl/cpu_pkg.sv
// Shared load/store size codes, cache FSM state and line layout for the L1 data cache.
// Tags are stored zero-extended to TAG_MAX_W so a single line type serves every ADDR_W/LINES setting.
package cpu_pkg;

    localparam logic [2:0] MASK_B  = 3'b000;
    localparam logic [2:0] MASK_H  = 3'b001;
    localparam logic [2:0] MASK_W  = 3'b010;
    localparam logic [2:0] MASK_BU = 3'b100;
    localparam logic [2:0] MASK_HU = 3'b101;

    localparam int TAG_MAX_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WTHRU = 2'd2,
        RESP  = 2'd3
    } cache_state_t;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [31:0]          data;
    } cache_line_t;

    function automatic logic load_mask_ok(input logic [2:0] m);
        return (m == MASK_B) || (m == MASK_H) || (m == MASK_W) ||
               (m == MASK_BU) || (m == MASK_HU);
    endfunction

    // Stores only come in signed-code flavours; the unsigned codes are load-only.
    function automatic logic store_mask_ok(input logic [2:0] m);
        return (m == MASK_B) || (m == MASK_H) || (m == MASK_W);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte/halfword lane logic: STORE=1 merges wdata_i into word_i, STORE=0 extracts and extends from word_i.
// Purely combinational; the cache instantiates one of each.
module lsu_align
    import cpu_pkg::*;
#(
    parameter bit STORE = 1'b0
) (
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  logic [2:0]  mask_i,
    input  logic [1:0]  off_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] merged;
    logic [31:0] extracted;

    always_comb begin
        byte_sel  = word_i[{off_i, 3'b000} +: 8];
        half_sel  = off_i[1] ? word_i[31:16] : word_i[15:0];
        merged    = word_i;
        extracted = '0;
        case (mask_i)
            MASK_B: begin
                merged[{off_i, 3'b000} +: 8] = wdata_i[7:0];
                extracted = {{24{byte_sel[7]}}, byte_sel};
            end
            MASK_H: begin
                merged[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
                extracted = {{16{half_sel[15]}}, half_sel};
            end
            MASK_W: begin
                merged    = wdata_i;
                extracted = word_i;
            end
            MASK_BU: extracted = {24'b0, byte_sel};
            MASK_HU: extracted = {16'b0, half_sel};
            default: ;
        endcase
        result_o = STORE ? merged : extracted;
    end

endmodule

// File: rtl/cache_l1_dm.sv
// Direct-mapped, write-through, one-word-line L1 data cache with a req/ack memory port.
// Define CACHE_STATS_EN to add saturating hit_cnt/miss_cnt outputs.
module cache_l1_dm
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int LINES  = 64
`ifdef CACHE_STATS_EN
    ,
    parameter int CNT_W  = 32
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        mask,
    input  logic [31:0]       data_in,
    output logic              stall,
    output logic [31:0]       data_out,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output cache_state_t      state_o
`ifdef CACHE_STATS_EN
    ,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
`endif
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    cache_state_t state_q, state_d;
    cache_line_t  lines_q [LINES];
    logic         pend_q;
    logic         mem_req_q, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]  mem_wdata_q;

    logic [IDX_W-1:0]     idx;
    logic [TAG_W-1:0]     req_tag;
    logic [TAG_MAX_W-1:0] tag_ext;
    logic [ADDR_W-1:0]    word_addr;
    cache_line_t          line_rd;
    logic                 hit, ld_req, st_req;
    logic [31:0]          merge_old, merged_word, load_word;

    assign idx       = addr[IDX_W+1:2];
    assign req_tag   = addr[ADDR_W-1:IDX_W+2];
    assign tag_ext   = TAG_MAX_W'(req_tag);
    assign word_addr = {addr[ADDR_W-1:2], 2'b00};
    assign line_rd   = lines_q[idx];
    assign hit       = line_rd.valid && (line_rd.tag == tag_ext);
    assign ld_req    = rd_en && !wr_en && load_mask_ok(mask);
    assign st_req    = wr_en && store_mask_ok(mask);

    // A partial-store miss merges into the word arriving from memory rather than the stale line.
    assign merge_old = (state_q == FILL) ? mem_rdata : line_rd.data;

    lsu_align #(.STORE(1'b1)) u_merge (
        .word_i  (merge_old),
        .wdata_i (data_in),
        .mask_i  (mask),
        .off_i   (addr[1:0]),
        .result_o(merged_word)
    );

    lsu_align #(.STORE(1'b0)) u_extract (
        .word_i  (line_rd.data),
        .wdata_i (data_in),
        .mask_i  (mask),
        .off_i   (addr[1:0]),
        .result_o(load_word)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (st_req)              state_d = (hit || mask == MASK_W) ? WTHRU : FILL;
                else if (ld_req && !hit) state_d = FILL;
            end
            FILL:    if (mem_ack) state_d = pend_q ? WTHRU : RESP;
            WTHRU:   if (mem_ack) state_d = IDLE;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall    = 1'b0;
        data_out = '0;
        case (state_q)
            IDLE: begin
                stall = st_req || (ld_req && !hit);
                if (ld_req && hit) data_out = load_word;
            end
            FILL:    stall = 1'b1;
            WTHRU:   stall = !mem_ack;
            RESP:    if (ld_req) data_out = load_word;
            default: ;
        endcase
    end

    // Line storage and the registered memory port; only valid bits need a reset value.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LINES; i++) lines_q[i].valid <= 1'b0;
            pend_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (st_req) begin
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= word_addr;
                        if (hit || mask == MASK_W) begin
                            lines_q[idx] <= '{valid: 1'b1, tag: tag_ext, data: merged_word};
                            mem_we_q     <= 1'b1;
                            mem_wdata_q  <= merged_word;
                            pend_q       <= 1'b0;
                        end else begin
                            mem_we_q <= 1'b0;
                            pend_q   <= 1'b1;
                        end
                    end else if (ld_req && !hit) begin
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= word_addr;
                        pend_q     <= 1'b0;
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        if (pend_q) begin
                            lines_q[idx] <= '{valid: 1'b1, tag: tag_ext, data: merged_word};
                            mem_we_q     <= 1'b1;
                            mem_wdata_q  <= merged_word;
                        end else begin
                            lines_q[idx] <= '{valid: 1'b1, tag: tag_ext, data: mem_rdata};
                            mem_req_q    <= 1'b0;
                        end
                    end
                end
                WTHRU: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        pend_q    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign state_o   = state_q;

`ifdef CACHE_STATS_EN
    logic [CNT_W-1:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == IDLE && (ld_req || st_req)) begin
            if (hit && hit_cnt_q != '1)   hit_cnt_q  <= hit_cnt_q + 1'b1;
            if (!hit && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule
